// File: rtl/pattern_pkg.sv
// pattern_pkg
// Shared definitions for the pattern phase driver:
//   - field offsets of the register file as functions of NUM_TWEAKS
//   - NUM_FIELDS formula (2*NUM_TWEAKS + 6)
//   - off-state bit values for the P and N driver buses
// Field map:
//   0 PDRIVE, 1 NDRIVE, 2 P_SENSE, 3 P_DELAY, 4..3+NT P_TWEAK,
//   4+NT N_SENSE, 5+NT N_DELAY, 6+NT..5+2NT N_TWEAK
package pattern_pkg;

  localparam int F_PDRIVE  = 0;
  localparam int F_NDRIVE  = 1;
  localparam int F_P_SENSE = 2;
  localparam int F_P_DELAY = 3;

  // P driver is active-low style: all ones means switched off.
  localparam logic P_OFF_BIT = 1'b1;
  localparam logic N_OFF_BIT = 1'b0;

  function automatic int num_fields(input int nt);
    return 2 * nt + 6;
  endfunction

  function automatic int p_tweak_off(input int k);
    return 4 + k;
  endfunction

  function automatic int n_sense_off(input int nt);
    return 4 + nt;
  endfunction

  function automatic int n_delay_off(input int nt);
    return 5 + nt;
  endfunction

  function automatic int n_tweak_off(input int nt, input int k);
    return 6 + nt + k;
  endfunction

endpackage

// File: rtl/pattern_phase_driver_if.sv
// pattern_phase_driver_if
// Register-file access and bank-swap bus of the pattern phase driver.
//   wr_en/wr_addr/wr_data : write into the shadow bank
//   rd_addr/rd_data       : registered readback of the active bank
//   swap_req/swap_ack     : shadow-to-active promotion handshake
// Handshake: swap_req is a request that may be a single-cycle pulse or a
// held level; the slave latches it as pending and answers with swap_ack,
// a one-cycle pulse in the cycle after promotion actually happened.
// Requests seen while already pending merge into the one outstanding request.
// Modports: master (bus owner / testbench side), slave (the driver).
interface pattern_phase_driver_if
  import pattern_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_TWEAKS = 8
);
  localparam int AW = $clog2(num_fields(NUM_TWEAKS));

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             swap_req;
  logic             swap_ack;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, swap_req,
    input  rd_data, swap_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, swap_req,
    output rd_data, swap_ack
  );

endinterface

// File: rtl/field_bank.sv
// field_bank
// Double-buffered register file. Writes land in the shadow bank; promote
// copies the whole shadow bank into the active bank. A write in the promote
// cycle lands in the shadow only (the copy takes the pre-write contents).
// Ports:
//   clk, rst                : clock, async active-high reset (both banks 0)
//   wr_en, wr_addr, wr_data : shadow write, out-of-range addresses ignored
//   promote                 : copy shadow -> active
//   rd_addr, rd_data        : registered read of the active bank, 0 if out of range
//   active_flat             : whole active bank, field i at [i*WIDTH +: WIDTH]
module field_bank #(
  parameter int WIDTH      = 8,
  parameter int NUM_FIELDS = 22,
  parameter int AW         = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        promote,
  input  logic [AW-1:0]               rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic [NUM_FIELDS*WIDTH-1:0] active_flat
);

  localparam logic [AW:0] NF_LIM = (AW+1)'(NUM_FIELDS);

  logic [WIDTH-1:0] shadow_q [NUM_FIELDS];
  logic [WIDTH-1:0] active_q [NUM_FIELDS];
  logic             wr_hit;
  logic             rd_hit;

  assign wr_hit = wr_en && ({1'b0, wr_addr} < NF_LIM);
  assign rd_hit = ({1'b0, rd_addr} < NF_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (promote) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_hit) begin
        shadow_q[wr_addr] <= wr_data;
      end
      rd_data <= rd_hit ? active_q[rd_addr] : '0;
    end
  end

  always_comb begin
    active_flat = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      active_flat[i*WIDTH +: WIDTH] = active_q[i];
    end
  end

endmodule

// File: rtl/pattern_phase_driver.sv
// pattern_phase_driver
// Drives P/N output buses plus sense/delay/tweak buses from a double-buffered
// field bank, selecting the P_ or N_ field set by the registered phase input.
// Ports:
//   clk, rst     : clock, async active-high reset
//   pwm          : phase input, 1 = high-driving phase, 0 = low-driving phase
//   bus          : pattern_phase_driver_if.slave (shadow writes, readback, swap)
//   slot_sel     : one-hot slot counter, restarts at bit 0 on every phase change
//   p_drive, n_drive, tweak_sense, tweak_delay : WIDTH-bit driver buses
//   tweak_drive  : NUM_TWEAKS buses, bus k at [k*WIDTH +: WIDTH]
// Optional feature macro PATTERN_DEADTIME_EN: after each phase change both
// drivers are held off and tweaks forced to 0 for DEADTIME cycles; a change
// inside the dead time restarts the count. Without it, no dead time.
module pattern_phase_driver
  import pattern_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_TWEAKS = 8,
  parameter int NUM_SLOTS  = 8,
  parameter int DEADTIME   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pwm,
  pattern_phase_driver_if.slave       bus,
  output logic [NUM_SLOTS-1:0]        slot_sel,
  output logic [WIDTH-1:0]            p_drive,
  output logic [WIDTH-1:0]            n_drive,
  output logic [WIDTH-1:0]            tweak_sense,
  output logic [WIDTH-1:0]            tweak_delay,
  output logic [NUM_TWEAKS*WIDTH-1:0] tweak_drive
);

  localparam int NUM_FIELDS = num_fields(NUM_TWEAKS);
  localparam int AW         = $clog2(NUM_FIELDS);
  localparam int F_N_SENSE  = n_sense_off(NUM_TWEAKS);
  localparam int F_N_DELAY  = n_delay_off(NUM_TWEAKS);

  localparam logic [NUM_SLOTS-1:0] SLOT_FIRST = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_SLOTS-1:0] SLOT_LAST  = {1'b1, {(NUM_SLOTS-1){1'b0}}};

  if (DEADTIME < 1 || DEADTIME > 15) begin : g_deadtime_range
    $error("pattern_phase_driver: DEADTIME must be in 1..15");
  end

  logic                        pwm_q;
  logic                        change;
  logic                        rise;
  logic                        pending;
  logic                        promote;
  logic                        swap_ack_q;
  logic                        dead;
  logic                        tweak_gate;
  logic [WIDTH-1:0]            rd_data_w;
  logic [NUM_FIELDS*WIDTH-1:0] active_flat;
  logic [NUM_TWEAKS*WIDTH-1:0] tweak_raw_q;

  logic [WIDTH-1:0]            p_nxt;
  logic [WIDTH-1:0]            n_nxt;
  logic [WIDTH-1:0]            sense_nxt;
  logic [WIDTH-1:0]            delay_nxt;
  logic [NUM_TWEAKS*WIDTH-1:0] tweak_nxt;

  assign change  = pwm ^ pwm_q;
  assign rise    = pwm & ~pwm_q;
  // Promotion is tied to the start of a high-driving phase so the new field
  // set never takes effect in the middle of a phase.
  assign promote = rise & pending;

  field_bank #(
    .WIDTH      (WIDTH),
    .NUM_FIELDS (NUM_FIELDS),
    .AW         (AW)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .wr_data     (bus.wr_data),
    .promote     (promote),
    .rd_addr     (bus.rd_addr),
    .rd_data     (rd_data_w),
    .active_flat (active_flat)
  );

  assign bus.rd_data  = rd_data_w;
  assign bus.swap_ack = swap_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q      <= 1'b0;
      pending    <= 1'b0;
      swap_ack_q <= 1'b0;
      slot_sel   <= SLOT_LAST;
    end else begin
      pwm_q      <= pwm;
      swap_ack_q <= promote;
      if (promote) begin
        pending <= 1'b0;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end
      if (change) begin
        slot_sel <= SLOT_FIRST;
      end else if (!slot_sel[NUM_SLOTS-1]) begin
        slot_sel <= slot_sel << 1;
      end
    end
  end

`ifdef PATTERN_DEADTIME_EN
  localparam logic [3:0] DT_LOAD = 4'(DEADTIME);
  logic [3:0] dt_cnt;

  // Loaded on the change edge, so the first dead output is the one computed
  // from the new pwm_q; reloading on a fresh change restarts the dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_cnt <= '0;
    end else if (change) begin
      dt_cnt <= DT_LOAD;
    end else if (dt_cnt != '0) begin
      dt_cnt <= dt_cnt - 4'd1;
    end
  end

  assign dead = (dt_cnt != '0);
`else
  assign dead = 1'b0;
`endif

  always_comb begin
    p_nxt     = {WIDTH{P_OFF_BIT}};
    n_nxt     = {WIDTH{N_OFF_BIT}};
    sense_nxt = '0;
    delay_nxt = '0;
    tweak_nxt = '0;
    if (pwm_q) begin
      p_nxt     = active_flat[F_PDRIVE*WIDTH +: WIDTH];
      sense_nxt = active_flat[F_P_SENSE*WIDTH +: WIDTH];
      delay_nxt = active_flat[F_P_DELAY*WIDTH +: WIDTH];
      for (int k = 0; k < NUM_TWEAKS; k++) begin
        tweak_nxt[k*WIDTH +: WIDTH] = active_flat[p_tweak_off(k)*WIDTH +: WIDTH];
      end
    end else begin
      n_nxt     = active_flat[F_NDRIVE*WIDTH +: WIDTH];
      sense_nxt = active_flat[F_N_SENSE*WIDTH +: WIDTH];
      delay_nxt = active_flat[F_N_DELAY*WIDTH +: WIDTH];
      for (int k = 0; k < NUM_TWEAKS; k++) begin
        tweak_nxt[k*WIDTH +: WIDTH] = active_flat[n_tweak_off(NUM_TWEAKS, k)*WIDTH +: WIDTH];
      end
    end
    if (dead) begin
      p_nxt     = {WIDTH{P_OFF_BIT}};
      n_nxt     = {WIDTH{N_OFF_BIT}};
      tweak_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_drive     <= {WIDTH{P_OFF_BIT}};
      n_drive     <= {WIDTH{N_OFF_BIT}};
      tweak_sense <= '0;
      tweak_delay <= '0;
      tweak_raw_q <= '0;
    end else begin
      p_drive     <= p_nxt;
      n_drive     <= n_nxt;
      tweak_sense <= sense_nxt;
      tweak_delay <= delay_nxt;
      tweak_raw_q <= tweak_nxt;
    end
  end

  // Delayed-tweak mode: with sense bit 0 set, tweaks stay quiet until the
  // slot counter has run out to its last slot in the current phase.
  assign tweak_gate  = ~slot_sel[NUM_SLOTS-1] & tweak_sense[0];
  assign tweak_drive = tweak_gate ? '0 : tweak_raw_q;

endmodule
